icache_s2_nway: RTL
===================

# icache_s2_nway

Second pipeline stage of the instruction cache, generalised to WAYS-way set associativity and configurable line length. It compares the tags read in stage 1 against the physical address and returns hit data to the fetch unit. On a miss or an uncached access it runs a burst refill over the AXI read channel, one beat at a time, and captures the requested word as it arrives. It then writes the completed line back to the chosen way, selected by per-set round-robin replacement that prefers invalid ways.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, 2..8
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16
- INDEX_W, 7, set index bits; TAG_W = 32 − INDEX_W − log2(LINE_WORDS) − 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  1  valid fetch request from stage 1 this cycle
- paddr_i  in  32  physical fetch address
- cached_i  in  1  1 = cacheable, 0 = uncached single-word read
- tag_i  in  WAYS*TAG_W  stage-1 tags; way w is at [w*TAG_W +: TAG_W]
- valid_i  in  WAYS  stage-1 valid bits
- data_i  in  WAYS*32  stage-1 word for each way
- cpu_ack_i  in  1  fetch unit consumes rdata_o this cycle
- axi_req_o  out  1  read address request
- axi_addr_o  out  32  line-aligned address (cached), or word-aligned address (uncached)
- axi_len_o  out  4  beats − 1; LINE_WORDS−1 when cached, 0 when uncached
- axi_ack_i  in  1  address accepted
- axi_rvalid_i / axi_rlast_i  in  1 / 1  read beat valid / last beat
- axi_rdata_i  in  32  read beat data
- refill_we_o  out  1  one-cycle line write to tag/data RAMs
- refill_way_o  out  log2(WAYS)  victim way
- refill_index_o  out  INDEX_W  set index
- refill_tag_o  out  TAG_W  tag written; the valid bit is written as 1
- refill_line_o  out  LINE_WORDS*32  line; word k is at [k*32 +: 32]
- stall_o  out  1  hold stage 1 and the fetch unit
- rdata_o  out  32  instruction word
- rdata_valid_o  out  1  rdata_o is valid

## Operation
Hit logic:
- hit[w] = valid_i[w] && tag_i[w] == paddr_i tag field.
- hit = req_i && cached_i && |hit.
- If more than one way hits, the lowest-numbered way wins.

Victim selection:
- If any way is invalid, the victim is the lowest-numbered invalid way.
- Otherwise the victim is rr[index]. rr is a per-set log2(WAYS)-bit counter array, reset to 0.
- rr[index] increments modulo WAYS on every refill write to that set.

FSM states IDLE, REQ, REFILL, WRITE, DONE:
- IDLE: on req_i && !hit, latch paddr, cached_i and the victim, then go to REQ.
- REQ: axi_req_o = 1, held until axi_ack_i. axi_addr_o and axi_len_o stay stable during REQ. On axi_ack_i, go to REFILL.
- REFILL: on each axi_rvalid_i, store the beat into line buffer word beat_cnt and increment beat_cnt (wraps modulo LINE_WORDS).
  - When beat_cnt equals the latched word offset, also capture the beat into crit_word. Uncached reads use offset 0.
  - On axi_rvalid_i && axi_rlast_i, go to WRITE if cached, else to DONE.
- WRITE: refill_we_o = 1 for exactly one cycle, with the latched index, tag and victim. Then go to DONE.
- DONE: rdata_o = crit_word and rdata_valid_o = 1. On cpu_ack_i, go to IDLE.

Outputs:
- stall_o = (state != IDLE) || (req_i && !hit).
- In IDLE, rdata_o = data_i of the hit way and rdata_valid_o = hit.
- axi_rvalid_i outside REFILL is ignored.
- The line buffer is not cleared between refills.

## Timing
- Reset values: state IDLE; all outputs 0; rr array, beat_cnt, crit_word and line buffer all 0.
- Hit: zero-latency combinational data, stall_o = 0.
- Miss: stall_o rises in the same cycle as the miss. axi_req_o rises on the next cycle.
- A cached miss with an immediate ack and back-to-back beats gives rdata_valid_o 1 + 1 + LINE_WORDS + 1 cycles after the miss cycle.
- While stall_o = 1, req_i, paddr_i and stage-1 inputs are don't-care; all working values are latched.
- Reset asserted mid-refill returns the FSM to IDLE immediately. The AXI master is reset by the same rst_n.
- If rlast arrives before LINE_WORDS beats, unfilled words keep stale data and the line is still written. This is a protocol violation, flagged by an assertion in the bench.

## Test plan
- Hit in way 1 (WAYS=4): tag_i way1 = paddr tag, valid_i = 4'b0010 → rdata_o = data_i[63:32], rdata_valid_o = 1, stall_o = 0, axi_req_o stays 0.
- Cached miss at paddr 0x0000_1014: axi_addr_o = 0x0000_1000, axi_len_o = 7. Beats 0xA0..0xA7 → crit_word = 0xA5. refill_we_o pulses once with index 0x00 and tag 0x00001, refill_line_o word k = 0xA0+k. Held in DONE until cpu_ack_i.
- Uncached read at 0x1FC0_0008: axi_addr_o = 0x1FC0_0008, axi_len_o = 0. One beat 0xDEADBEEF → rdata_o = 0xDEADBEEF, refill_we_o never asserted.
- Replacement, WAYS=2 with both ways valid: three misses to set 3 → victims 0, 1, 0 (rr wraps). A set with valid_i = 2'b10 → victim 0 regardless of rr.
- axi_ack_i delayed 5 cycles and gaps between beats → axi_req_o held with a stable address. Stray rvalid in IDLE has no effect.
- rst_n asserted after the third beat → all outputs 0 asynchronously. The next request behaves as in the second scenario.

Source files
------------

// File: rtl/icache_s2_nway.sv
// ============================================================================
//  Module   : icache_s2_nway
//  Brief    : Instruction cache stage 2. Tag compare and hit return for a
//             WAYS-way set-associative cache, AXI burst refill on miss or
//             uncached access, critical-word capture, round-robin victim
//             selection per set that prefers invalid ways.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module icache_s2_nway #(
    parameter  int WAYS       = 2,
    parameter  int LINE_WORDS = 8,
    parameter  int INDEX_W    = 7,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int TAG_W      = 32 - INDEX_W - OFF_W - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic [31:0]              paddr_i,
    input  logic                     cached_i,
    input  logic [WAYS*TAG_W-1:0]    tag_i,
    input  logic [WAYS-1:0]          valid_i,
    input  logic [WAYS*32-1:0]       data_i,
    input  logic                     cpu_ack_i,
    output logic                     axi_req_o,
    output logic [31:0]              axi_addr_o,
    output logic [3:0]               axi_len_o,
    input  logic                     axi_ack_i,
    input  logic                     axi_rvalid_i,
    input  logic                     axi_rlast_i,
    input  logic [31:0]              axi_rdata_i,
    output logic                     refill_we_o,
    output logic [WAY_W-1:0]         refill_way_o,
    output logic [INDEX_W-1:0]       refill_index_o,
    output logic [TAG_W-1:0]         refill_tag_o,
    output logic [LINE_WORDS*32-1:0] refill_line_o,
    output logic                     stall_o,
    output logic [31:0]              rdata_o,
    output logic                     rdata_valid_o
);

    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_REQ     = 3'd1;
    localparam logic [2:0]  c_ST_REFILL  = 3'd2;
    localparam logic [2:0]  c_ST_WRITE   = 3'd3;
    localparam logic [2:0]  c_ST_DONE    = 3'd4;
    localparam int          c_SETS       = 1 << INDEX_W;
    localparam logic [31:0] c_LINE_MASK  = 32'((1 << (OFF_W + 2)) - 1);
    localparam logic [3:0]  c_LEN_CACHED = 4'(LINE_WORDS - 1);

    logic [2:0]              r_state;
    logic [31:0]             r_paddr;
    logic                    r_cached;
    logic [WAY_W-1:0]        r_victim;
    logic [OFF_W-1:0]        r_off;
    logic [OFF_W-1:0]        r_beat_cnt;
    logic [31:0]             r_crit;
    logic [LINE_WORDS*32-1:0] r_line;
    logic [WAY_W-1:0]        r_rr [c_SETS];

    logic [TAG_W-1:0]        w_tag;
    logic [INDEX_W-1:0]      w_index;
    logic [OFF_W-1:0]        w_off;
    logic [INDEX_W-1:0]      w_lat_index;
    logic [TAG_W-1:0]        w_lat_tag;
    logic [WAYS-1:0]         w_way_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [WAY_W-1:0]        w_inv_way;
    logic [WAY_W-1:0]        w_victim;
    logic [31:0]             w_hit_data;
    logic                    w_hit;
    logic                    w_miss;

    assign w_tag       = paddr_i[31 -: TAG_W];
    assign w_index     = paddr_i[OFF_W + 2 +: INDEX_W];
    assign w_off       = paddr_i[2 +: OFF_W];
    assign w_lat_index = r_paddr[OFF_W + 2 +: INDEX_W];
    assign w_lat_tag   = r_paddr[31 -: TAG_W];

    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            assign w_way_hit[w] = valid_i[w] && (tag_i[w*TAG_W +: TAG_W] == w_tag);
        end
    endgenerate

    // Lowest-numbered hitting way and lowest-numbered invalid way.
    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_way_hit[w]) w_hit_way = WAY_W'(w);
            if (!valid_i[w])  w_inv_way = WAY_W'(w);
        end
    end

    assign w_hit      = req_i && cached_i && (|w_way_hit);
    assign w_miss     = req_i && !w_hit;
    assign w_hit_data = data_i[int'(w_hit_way)*32 +: 32];
    assign w_victim   = (&valid_i) ? r_rr[w_index] : w_inv_way;

    // Refill FSM: latch the miss, request the burst, gather beats, write line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_paddr    <= '0;
            r_cached   <= 1'b0;
            r_victim   <= '0;
            r_off      <= '0;
            r_beat_cnt <= '0;
            r_crit     <= '0;
            r_line     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss) begin
                        r_paddr    <= paddr_i;
                        r_cached   <= cached_i;
                        r_victim   <= w_victim;
                        // An uncached read is a single beat, so its word is beat 0.
                        r_off      <= cached_i ? w_off : '0;
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (axi_ack_i) r_state <= c_ST_REFILL;
                end
                c_ST_REFILL: begin
                    if (axi_rvalid_i) begin
                        r_line[int'(r_beat_cnt)*32 +: 32] <= axi_rdata_i;
                        if (r_beat_cnt == r_off) r_crit <= axi_rdata_i;
                        r_beat_cnt <= r_beat_cnt + OFF_W'(1);
                        if (axi_rlast_i) r_state <= r_cached ? c_ST_WRITE : c_ST_DONE;
                    end
                end
                c_ST_WRITE: begin
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (cpu_ack_i) r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Per-set round-robin pointer advances on every line write to that set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < c_SETS; s++) r_rr[s] <= '0;
        end else if (r_state == c_ST_WRITE) begin
            r_rr[w_lat_index] <= r_rr[w_lat_index] + WAY_W'(1);
        end
    end

    // State-decoded outputs; inactive fields are held at zero.
    always_comb begin
        axi_req_o      = 1'b0;
        axi_addr_o     = '0;
        axi_len_o      = '0;
        refill_we_o    = 1'b0;
        refill_way_o   = '0;
        refill_index_o = '0;
        refill_tag_o   = '0;
        rdata_o        = '0;
        rdata_valid_o  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                rdata_valid_o = w_hit;
                if (w_hit) rdata_o = w_hit_data;
            end
            c_ST_REQ: begin
                axi_req_o  = 1'b1;
                axi_addr_o = r_cached ? (r_paddr & ~c_LINE_MASK) : (r_paddr & ~32'h3);
                axi_len_o  = r_cached ? c_LEN_CACHED : 4'd0;
            end
            c_ST_WRITE: begin
                refill_we_o    = 1'b1;
                refill_way_o   = r_victim;
                refill_index_o = w_lat_index;
                refill_tag_o   = w_lat_tag;
            end
            c_ST_DONE: begin
                rdata_o       = r_crit;
                rdata_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign refill_line_o = r_line;
    assign stall_o       = (r_state != c_ST_IDLE) || w_miss;

endmodule

`default_nettype wire
